// File: rtl/ddr2_rw_sched.sv
// ddr2_rw_sched: write/read-back pattern scheduler for the DDR2 test top.
// Writes NUM_BURSTS pattern bursts, reads them back, counts errors.
module ddr2_rw_sched #(
  parameter int         ADDR_WIDTH   = 26,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [7:0] BURST_LEN    = 8'd32,
  parameter int         ADDR_STEP    = 64,
  parameter int         NUM_BURSTS   = 16,
  parameter int         GAP_CYCLES   = 100,
  parameter int         PATTERN_SEED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  output logic                  wr_trig,
  output logic [7:0]            wr_len,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_data_en,
  input  logic                  wr_ready,
  input  logic                  wr_done,
  output logic                  rd_trig,
  output logic [7:0]            rd_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_en,
  input  logic                  rd_ready,
  input  logic                  rd_done,
  output logic [15:0]           err_cnt,
  output logic [15:0]           pass_cnt,
  output logic                  busy,
  output logic                  led
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, WR_GAP,
    RD_REQ, RD_WAIT, RD_GAP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(ADDR_STEP);
  localparam logic [DATA_WIDTH-1:0] SEED =
    DATA_WIDTH'(PATTERN_SEED);
  localparam logic [15:0] LAST = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] GAP_LD =
    32'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [16:0] BLEN = 17'(BURST_LEN);

  state_t                  state, state_d;
  logic                    wr_trig_d, rd_trig_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d, rd_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_d, exp_q, exp_d;
  logic [15:0]             beat_q, beat_d, beat_inc;
  logic [15:0]             burst_q, burst_d;
  logic [31:0]             gap_q, gap_d;
  logic [15:0]             pass_d, pass_inc, err_d;
  logic [16:0]             wr_fin, rd_fin, err_sum;
  logic [1:0]              err_inc;
  logic                    busy_d, led_d;

  assign wr_len = BURST_LEN;
  assign rd_len = BURST_LEN;

  // next-state, datapath and error accounting
  always_comb begin
    state_d   = state;
    wr_trig_d = wr_trig;
    rd_trig_d = rd_trig;
    wr_addr_d = wr_addr;
    rd_addr_d = rd_addr;
    wr_data_d = wr_data;
    exp_d     = exp_q;
    beat_d    = beat_q;
    burst_d   = burst_q;
    gap_d     = gap_q;
    pass_d    = pass_cnt;
    err_inc   = 2'd0;
    pass_inc  = pass_cnt + 16'd1;
    beat_inc  = (beat_q == 16'hFFFF) ? beat_q
                                     : beat_q + 16'd1;
    wr_fin    = {1'b0, beat_q} + {16'd0, wr_data_en};
    rd_fin    = {1'b0, beat_q} + {16'd0, rd_data_en};
    unique case (state)
      IDLE: begin
        wr_trig_d = 1'b0;
        rd_trig_d = 1'b0;
        if (init_end) begin
          state_d   = WR_REQ;
          burst_d   = 16'd0;
          wr_addr_d = '0;
          wr_data_d = SEED + DATA_WIDTH'(pass_cnt);
        end
      end
      WR_REQ: begin
        err_inc = {1'b0, wr_done} + {1'b0, rd_done};
        if (wr_trig && wr_ready) begin
          wr_trig_d = 1'b0;
          beat_d    = 16'd0;
          state_d   = WR_WAIT;
        end else begin
          wr_trig_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (wr_data_en) begin
          wr_data_d = wr_data + 1'b1;
          beat_d    = beat_inc;
        end
        if (wr_done) begin
          if (wr_fin != BLEN) err_inc = 2'd1;
          if (burst_q == LAST) begin
            state_d   = RD_REQ;
            burst_d   = 16'd0;
            rd_addr_d = '0;
            exp_d     = SEED + DATA_WIDTH'(pass_cnt);
          end else begin
            wr_addr_d = wr_addr + STEP;
            burst_d   = burst_q + 16'd1;
            gap_d     = GAP_LD;
            state_d   = (GAP_CYCLES == 0) ? WR_REQ : WR_GAP;
          end
        end
      end
      WR_GAP: begin
        if (gap_q == 32'd0) state_d = WR_REQ;
        else gap_d = gap_q - 32'd1;
      end
      RD_REQ: begin
        err_inc = {1'b0, wr_done} + {1'b0, rd_done};
        if (rd_trig && rd_ready) begin
          rd_trig_d = 1'b0;
          beat_d    = 16'd0;
          state_d   = RD_WAIT;
        end else begin
          rd_trig_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (rd_data_en) begin
          if (rd_data != exp_q) err_inc = err_inc + 2'd1;
          if (beat_q >= BLEN[15:0]) err_inc = err_inc + 2'd1;
          exp_d  = exp_q + 1'b1;
          beat_d = beat_inc;
        end
        if (rd_done) begin
          if (rd_fin != BLEN) err_inc = err_inc + 2'd1;
          if (burst_q == LAST) begin
            state_d   = WR_REQ;
            pass_d    = pass_inc;
            burst_d   = 16'd0;
            wr_addr_d = '0;
            wr_data_d = SEED + DATA_WIDTH'(pass_inc);
          end else begin
            rd_addr_d = rd_addr + STEP;
            burst_d   = burst_q + 16'd1;
            gap_d     = GAP_LD;
            state_d   = (GAP_CYCLES == 0) ? RD_REQ : RD_GAP;
          end
        end
      end
      RD_GAP: begin
        if (gap_q == 32'd0) state_d = RD_REQ;
        else gap_d = gap_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
    // losing init_end abandons the in-flight burst silently
    if (state != IDLE && !init_end) begin
      state_d   = IDLE;
      wr_trig_d = 1'b0;
      rd_trig_d = 1'b0;
      wr_addr_d = '0;
      rd_addr_d = '0;
      wr_data_d = wr_data;
      exp_d     = exp_q;
      beat_d    = 16'd0;
      burst_d   = 16'd0;
      gap_d     = 32'd0;
      pass_d    = pass_cnt;
      err_inc   = 2'd0;
    end
    err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    busy_d  = (state_d != IDLE);
    led_d   = (pass_cnt != 16'd0) && (err_cnt == 16'd0);
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_trig  <= 1'b0;
      rd_trig  <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_data  <= SEED;
      exp_q    <= SEED;
      beat_q   <= 16'd0;
      burst_q  <= 16'd0;
      gap_q    <= 32'd0;
      pass_cnt <= 16'd0;
      err_cnt  <= 16'd0;
      busy     <= 1'b0;
      led      <= 1'b0;
    end else begin
      state    <= state_d;
      wr_trig  <= wr_trig_d;
      rd_trig  <= rd_trig_d;
      wr_addr  <= wr_addr_d;
      rd_addr  <= rd_addr_d;
      wr_data  <= wr_data_d;
      exp_q    <= exp_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      pass_cnt <= pass_d;
      err_cnt  <= err_d;
      busy     <= busy_d;
      led      <= led_d;
    end
  end

endmodule

// File: tb/tb_ddr2_rw_sched.sv
// tb_ddr2_rw_sched: scoreboard bench for ddr2_rw_sched.
// Write/read master models around a word memory.
module tb_ddr2_rw_sched;

  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_end = 1'b0;
  logic          wr_trig, rd_trig;
  logic [7:0]    wr_len, rd_len;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data = '0;
  logic          wr_data_en = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_done = 1'b0;
  logic          rd_data_en = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_done = 1'b0;
  logic [15:0]   err_cnt, pass_cnt;
  logic          busy, led;

  ddr2_rw_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_end   (init_end),
    .wr_trig    (wr_trig),
    .wr_len     (wr_len),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_data_en (wr_data_en),
    .wr_ready   (wr_ready),
    .wr_done    (wr_done),
    .rd_trig    (rd_trig),
    .rd_len     (rd_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_data_en (rd_data_en),
    .rd_ready   (rd_ready),
    .rd_done    (rd_done),
    .err_cnt    (err_cnt),
    .pass_cnt   (pass_cnt),
    .busy       (busy),
    .led        (led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0]   q_waddr[$];
  logic [31:0]   q_raddr[$];
  logic [31:0]   q_wdata[$];
  logic [DW-1:0] mem[int];

  bit mdl_on = 0;
  bit corrupt = 0;
  bit hang = 0;
  int short_idx = -1;
  int slow_idx = -1;
  int wburst = 0;
  int rburst = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_wa();
    if (q_waddr.size() == 0) return 32'hBAD0_0001;
    return q_waddr.pop_front();
  endfunction

  function automatic logic [31:0] pop_ra();
    if (q_raddr.size() == 0) return 32'hBAD0_0002;
    return q_raddr.pop_front();
  endfunction

  function automatic logic [31:0] pop_wd();
    if (q_wdata.size() == 0) return 32'hBAD0_0003;
    return q_wdata.pop_front();
  endfunction

  task automatic push_pass(input int p);
    for (int b = 0; b < 16; b++) begin
      q_waddr.push_back(32'(b * 64));
      q_raddr.push_back(32'(b * 64));
    end
    for (int i = 0; i < 512; i++)
      q_wdata.push_back(32'(1 + p + i));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic restart();
    mdl_on = 0;
    init_end = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q_waddr.delete();
    q_raddr.delete();
    q_wdata.delete();
    mem.delete();
    tick();
  endtask

  task automatic wait_pass(input int p, input int lim,
                           input string tag);
    int n = 0;
    while (pass_cnt != 16'(p) && n < lim) begin
      tick();
      n++;
    end
    chk(tag, pass_cnt, p);
  endtask

  // write master: accept trigger, consume beats, pulse done
  initial begin
    int wph, wcnt, wb, nb;
    logic [AW-1:0] wa;
    wph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mdl_on) begin
        wph = 0;
        wburst = 0;
        wr_ready = 1'b0;
        wr_data_en = 1'b0;
        wr_done = 1'b0;
      end else begin
        case (wph)
          0: begin
            wr_done = 1'b0;
            if (wr_trig) begin
              chk("wr_addr", 32'(wr_addr), pop_wa());
              wa = wr_addr;
              wcnt = (wburst == slow_idx) ? 50 : 0;
              if (wcnt == 0) begin
                wr_ready = 1'b1;
                wph = 2;
              end else begin
                wph = 1;
              end
            end
          end
          1: begin
            chk("wr_trig_hold", 32'(wr_trig), 1);
            wcnt--;
            if (wcnt == 0) begin
              wr_ready = 1'b1;
              wph = 2;
            end
          end
          default: begin
            if (wph == 2) begin
              wr_ready = 1'b0;
              chk("wr_trig_drop", 32'(wr_trig), 0);
              wb = 0;
              nb = (wburst == short_idx) ? 31 : 32;
              wph = 3;
            end
            if (wb < nb) begin
              wr_data_en = 1'b1;
              chk("wr_data", wr_data, pop_wd());
              mem[int'(wa) + wb] = wr_data;
              wb++;
            end else begin
              wr_data_en = 1'b0;
              wr_done = 1'b1;
              wburst++;
              wph = 0;
            end
          end
        endcase
      end
    end
  end

  // read master: return stored data, optionally corrupted
  initial begin
    int rph, rb, k;
    logic [AW-1:0] ra;
    logic [DW-1:0] d;
    rph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mdl_on) begin
        rph = 0;
        rburst = 0;
        rd_ready = 1'b0;
        rd_data_en = 1'b0;
        rd_done = 1'b0;
      end else begin
        case (rph)
          0: begin
            rd_done = 1'b0;
            if (rd_trig) begin
              chk("rd_addr", 32'(rd_addr), pop_ra());
              ra = rd_addr;
              rd_ready = 1'b1;
              rph = 2;
            end
          end
          default: begin
            if (rph == 2) begin
              rd_ready = 1'b0;
              chk("rd_trig_drop", 32'(rd_trig), 0);
              rb = 0;
              rph = 3;
            end
            if (hang || rb < 32) begin
              k = int'(ra) + rb;
              d = mem.exists(k) ? mem[k] : 32'hDEAD_BEEF;
              if (hang || (corrupt && ra == 128 && rb == 5))
                d = ~d;
              rd_data = d;
              rd_data_en = 1'b1;
              rb++;
            end else begin
              rd_data_en = 1'b0;
              rd_done = 1'b1;
              rburst++;
              rph = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    int n;
    logic [15:0] e0;
    repeat (3) tick();
    chk("rst_wr_trig", 32'(wr_trig), 0);
    chk("rst_rd_trig", 32'(rd_trig), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_wr_data", wr_data, 1);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_led", 32'(led), 0);
    chk("wr_len", 32'(wr_len), 32);
    chk("rd_len", 32'(rd_len), 32);
    rst_n = 1'b1;
    tick();

    // clean pass with ideal masters
    push_pass(0);
    push_pass(1);
    mdl_on = 1;
    init_end = 1'b1;
    tick();
    chk("busy_rise", 32'(busy), 1);
    chk("trig_lat1", 32'(wr_trig), 0);
    tick();
    chk("trig_lat2", 32'(wr_trig), 1);
    wait_pass(1, 12000, "pass0_done");
    chk("pass0_err", 32'(err_cnt), 0);
    chk("sb_wdata_left", q_wdata.size(), 512);
    chk("sb_waddr_left", q_waddr.size(), 16);
    chk("sb_raddr_left", q_raddr.size(), 16);
    tick();
    tick();
    chk("led_on", 32'(led), 1);

    // one corrupted read beat
    restart();
    corrupt = 1;
    push_pass(0);
    push_pass(1);
    mdl_on = 1;
    init_end = 1'b1;
    wait_pass(1, 12000, "pass0c_done");
    corrupt = 0;
    chk("corrupt_err", 32'(err_cnt), 1);
    n = 0;
    while (!wr_data_en && n < 500) begin
      tick();
      n++;
    end
    chk("p1_first_beat", wr_data, 2);
    repeat (20) tick();
    chk("led_off", 32'(led), 0);

    // init_end drop in read burst 7
    n = 0;
    while (!(rd_addr == 448 && rd_data_en) && n < 8000) begin
      tick();
      n++;
    end
    chk("rd7_reached", 32'(rd_addr), 448);
    e0 = err_cnt;
    chk("err_before_drop", 32'(e0), 1);
    init_end = 1'b0;
    mdl_on = 0;
    tick();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_wr_trig", 32'(wr_trig), 0);
    chk("drop_rd_trig", 32'(rd_trig), 0);
    chk("drop_rd_addr", 32'(rd_addr), 0);
    chk("drop_wr_addr", 32'(wr_addr), 0);
    chk("drop_err", 32'(err_cnt), 32'(e0));
    chk("drop_pass", 32'(pass_cnt), 1);
    tick();
    q_waddr.delete();
    q_raddr.delete();
    q_wdata.delete();
    push_pass(1);
    mdl_on = 1;
    init_end = 1'b1;
    tick();
    tick();
    chk("reinit_trig", 32'(wr_trig), 1);
    wait_pass(2, 12000, "pass1_done");
    chk("pass1_err", 32'(err_cnt), 32'(e0));

    // short write burst 3 and slow ready on burst 5
    restart();
    short_idx = 3;
    slow_idx = 5;
    push_pass(0);
    mdl_on = 1;
    init_end = 1'b1;
    n = 0;
    while (!(wr_done && wburst == 4) && n < 3000) begin
      tick();
      n++;
    end
    chk("short_done_seen", 32'(wburst), 4);
    e0 = err_cnt;
    chk("err_pre_short", 32'(e0), 0);
    tick();
    chk("err_short", 32'(err_cnt), 1);
    n = 0;
    while (wburst < 6 && n < 3000) begin
      tick();
      n++;
    end
    chk("wburst6", 32'(wburst), 6);
    chk("err_after_slow", 32'(err_cnt), 1);

    // async reset mid write burst
    n = 0;
    while (!wr_data_en && n < 500) begin
      tick();
      n++;
    end
    chk("wr6_beats", 32'(wr_data_en), 1);
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_trig", 32'(wr_trig), 0);
    chk("arst_wr_addr", 32'(wr_addr), 0);
    chk("arst_wr_data", wr_data, 1);
    chk("arst_err", 32'(err_cnt), 0);
    chk("arst_pass", 32'(pass_cnt), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_led", 32'(led), 0);
    mdl_on = 0;
    init_end = 1'b0;
    short_idx = -1;
    slow_idx = -1;
    tick();
    tick();
    rst_n = 1'b1;
    q_waddr.delete();
    q_raddr.delete();
    q_wdata.delete();
    mem.delete();
    tick();

    // error counter saturation on an endless bad read
    hang = 1;
    push_pass(0);
    mdl_on = 1;
    init_end = 1'b1;
    n = 0;
    while (err_cnt != 16'hFFFF && n < 45000) begin
      tick();
      n++;
    end
    chk("err_sat", 32'(err_cnt), 32'hFFFF);
    repeat (3) tick();
    chk("err_sat_busy", 32'(rd_data_en), 1);
    chk("err_sat_hold", 32'(err_cnt), 32'hFFFF);
    mdl_on = 0;
    hang = 0;
    init_end = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr2_rw_sched.md
Name: ddr2_rw_sched

Overview:
Self-checking traffic scheduler for the DDR2 test top. It sits on the user side of axi_wr_master and axi_rd_master. It sequences a pass of NUM_BURSTS write bursts, then reads back the same address range and compares every beat against the regenerated pattern. It counts mismatches and beat-count errors, loops passes indefinitely, and drives the board status LED.

Parameters:
ADDR_WIDTH, 26, user byte/word address width (ROW+COL+BA).
DATA_WIDTH, 32, user data width (2 x DQ).
BURST_LEN, 8'd32, beats per burst, driven on wr_len/rd_len.
ADDR_STEP, 64, address increment per burst.
NUM_BURSTS, 16, bursts per write or read phase (>=1).
GAP_CYCLES, 100, idle cycles between consecutive bursts (0 allowed).
PATTERN_SEED, 1, data value of the first beat of pass 0.

Ports:
clk  in  1  user clock (clk1 domain)
rst_n  in  1  async active-low reset
init_end  in  1  DDR2 init complete
wr_trig  out  1  write request, held until wr_ready
wr_len  out  8  constant BURST_LEN
wr_addr  out  ADDR_WIDTH  burst start address
wr_data  out  DATA_WIDTH  current write beat
wr_data_en  in  1  master consumed wr_data this cycle
wr_ready  in  1  write master accepts trigger
wr_done  in  1  write burst complete (1-cycle pulse)
rd_trig  out  1  read request, held until rd_ready
rd_len  out  8  constant BURST_LEN
rd_addr  out  ADDR_WIDTH  burst start address
rd_data  in  DATA_WIDTH  read beat
rd_data_en  in  1  rd_data valid
rd_ready  in  1  read master accepts trigger
rd_done  in  1  read burst complete (1-cycle pulse)
err_cnt  out  16  saturating error count
pass_cnt  out  16  completed passes, wraps
busy  out  1  high in any state except IDLE
led  out  1  status: pass_cnt!=0 and err_cnt==0

Behaviour:
- Reset values: wr_trig=0, rd_trig=0, wr_addr=rd_addr=0, wr_data=PATTERN_SEED, err_cnt=0, pass_cnt=0, busy=0, led=0, state=IDLE.
- wr_len/rd_len are constant BURST_LEN.
- States:
  - IDLE: wait for init_end=1. Go to WR_REQ with burst_idx=0, addr=0, wr_data=PATTERN_SEED+pass_cnt.
  - WR_REQ: wr_trig=1. When wr_trig&&wr_ready, drop wr_trig next cycle, clear beat_cnt, go to WR_WAIT.
  - WR_WAIT: each wr_data_en advances wr_data by 1 and beat_cnt by 1. On wr_done, compare final beat_cnt (including a same-cycle wr_data_en) with BURST_LEN; mismatch adds +1 err. Then:
    - burst_idx==NUM_BURSTS-1: go to RD_REQ with addr=0, exp=PATTERN_SEED+pass_cnt.
    - otherwise: wr_addr+=ADDR_STEP, burst_idx++, go to WR_GAP.
  - WR_GAP: count GAP_CYCLES cycles, then WR_REQ. GAP_CYCLES=0 goes straight to WR_REQ.
  - RD_REQ / RD_WAIT / RD_GAP: mirror the write states using rd_trig/rd_ready/rd_done/rd_addr.
    - Each rd_data_en compares rd_data with exp (+1 err on mismatch), then exp++ and beat_cnt++.
    - Beat count is checked at rd_done as for writes.
    - Beats after BURST_LEN count one error each and are still compared.
  - After the last read burst: pass_cnt++, go to WR_REQ for the next pass.
- Address arithmetic is modulo 2^ADDR_WIDTH (natural wrap). Data arithmetic is modulo 2^DATA_WIDTH.
- err_cnt saturates at 16'hFFFF. Two error sources in one cycle (data mismatch plus beat-count error) add 2, still saturating.
- Trigger hold: a trigger stays high until its ready is seen; it is never withdrawn early.
- wr_done/rd_done seen while in a REQ state (protocol violation): +1 err, ignored.
- init_end falling mid-operation:
  - Next cycle: IDLE, triggers low, addresses 0, beat/burst counters cleared.
  - err_cnt and pass_cnt are kept.
  - The in-flight burst is abandoned with no error charged.
- led is registered: led = (pass_cnt!=0)&&(err_cnt==0), updated every cycle. busy = (state!=IDLE), registered.
- Latency: trigger asserts 1 cycle after entering REQ. From init_end rising to first wr_trig: 2 cycles.

Test Plan:
- Defaults, ideal master model (ready 1 cycle after trig, 32 wr_data_en beats, done pulse, read returns stored data) -> after 16 writes + 16 reads: pass_cnt=1, err_cnt=0, led=1; wr_addr sequence 0,64,...,960; first beat 1, last beat of pass 512.
- Memory model corrupts one read beat (addr 128, beat 5) -> err_cnt=1 after pass 0; led stays 0 permanently; pass 1 starts with wr_data=2.
- Write master delivers 31 beats before wr_done on burst 3 -> err_cnt increments by exactly 1 at that wr_done; sequence continues to burst 4.
- wr_ready held low for 50 cycles -> wr_trig stays high all 50 cycles, drops the cycle after ready; no spurious second request.
- init_end deasserted during RD_WAIT of burst 7 -> next cycle IDLE, busy=0, triggers 0, err_cnt unchanged; on reassert, restarts at wr_addr=0 with wr_data=PATTERN_SEED+pass_cnt.
- rst_n pulsed low asynchronously mid-WR_WAIT -> all outputs at reset values immediately; err_cnt forced to 16'hFFFF then one more error -> stays 16'hFFFF.
